// File: rtl/data_sram_responder.sv
// Data-SRAM slave for the CPU core: byte-lane writes and fixed-latency reads.
// It checks each address against a window and clears the array after reset.
module data_sram_responder #(
    parameter int unsigned ADDR_W     = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int unsigned LATENCY    = 1,
    parameter bit          INIT_CLEAR = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        rd_valid,
    output logic        sram_err,
    output logic        sram_ready
);

    localparam int unsigned DEPTH    = 1 << ADDR_W;
    localparam logic [31:0] WIN_MASK = ~((32'd1 << (ADDR_W + 2)) - 32'd1);
    localparam int unsigned RSP_W    = 35;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam state_t RST_STATE = (INIT_CLEAR != 1'b0) ? ST_INIT : ST_RUN;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR_W-1:0]  r_init_idx;
    logic               r_ready;
    logic               w_clr_we;

    logic               w_acc;
    logic               w_in_win;
    logic               w_is_rd;
    logic [ADDR_W-1:0]  w_idx;

    logic               w_mem_we;
    logic [3:0]         w_mem_be;
    logic [ADDR_W-1:0]  w_mem_idx;
    logic [31:0]        w_mem_wdata;
    logic [31:0]        r_mem [DEPTH];

    // Response word layout: [34] valid, [33] read, [32] error, [31:0] data.
    logic [RSP_W-1:0]   w_rsp_in;
    logic [RSP_W-1:0]   w_rsp_tail;
    logic [31:0]        r_rdata;
    logic               r_rd_valid;
    logic               r_err;

    // State register and clear-sweep index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= RST_STATE;
            r_init_idx <= '0;
            r_ready    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt == ST_RUN);
            if (w_clr_we) begin
                r_init_idx <= r_init_idx + ADDR_W'(1);
            end
        end
    end

    // Next-state logic: sweep one word per cycle, then serve requests forever.
    always_comb begin
        w_state_nxt = r_state;
        w_clr_we    = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_clr_we = 1'b1;
                if (r_init_idx == {ADDR_W{1'b1}}) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_INIT;
                end
            end
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_INIT;
        endcase
    end

    assign w_acc    = data_sram_en & r_ready;
    assign w_in_win = ((data_sram_addr & WIN_MASK) == BASE_ADDR);
    assign w_idx    = data_sram_addr[ADDR_W+1:2];
    assign w_is_rd  = (data_sram_wen == 4'b0000);

    // The single write port is shared between the clear sweep and core writes.
    always_comb begin
        if (w_clr_we) begin
            w_mem_we    = 1'b1;
            w_mem_be    = 4'hF;
            w_mem_idx   = r_init_idx;
            w_mem_wdata = 32'h0000_0000;
        end else begin
            w_mem_we    = w_acc & ~w_is_rd & w_in_win;
            w_mem_be    = data_sram_wen;
            w_mem_idx   = w_idx;
            w_mem_wdata = data_sram_wdata;
        end
    end

    // Byte-lane write into the array; contents survive rst.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_mem_be[i]) begin
                    r_mem[w_mem_idx][8*i +: 8] <= w_mem_wdata[8*i +: 8];
                end
            end
        end
    end

    // Build the response word.  Out-of-window reads return zero data.
    always_comb begin
        w_rsp_in = {w_acc, w_is_rd, ~w_in_win, 32'h0000_0000};
        if (w_acc & w_is_rd & w_in_win) begin
            w_rsp_in[31:0] = r_mem[w_idx];
        end else begin
            w_rsp_in[31:0] = 32'h0000_0000;
        end
    end

    generate
        if (LATENCY == 1) begin : g_lat1
            assign w_rsp_tail = w_rsp_in;
        end else begin : g_latn
            logic [RSP_W-1:0] r_pipe [LATENCY-1];

            // Delay line; the output register supplies the final stage.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < int'(LATENCY) - 1; i++) begin
                        r_pipe[i] <= '0;
                    end
                end else begin
                    r_pipe[0] <= w_rsp_in;
                    for (int i = 1; i < int'(LATENCY) - 1; i++) begin
                        r_pipe[i] <= r_pipe[i-1];
                    end
                end
            end

            assign w_rsp_tail = r_pipe[LATENCY-2];
        end
    endgenerate

    // Output stage: rdata changes only with a read response and holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata    <= 32'h0000_0000;
            r_rd_valid <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_rd_valid <= w_rsp_tail[34] & w_rsp_tail[33];
            r_err      <= w_rsp_tail[34] & w_rsp_tail[32];
            if (w_rsp_tail[34] & w_rsp_tail[33]) begin
                r_rdata <= w_rsp_tail[31:0];
            end
        end
    end

    assign data_sram_rdata = r_rdata;
    assign rd_valid        = r_rd_valid;
    assign sram_err        = r_err;
    assign sram_ready      = r_ready;

endmodule

// File: tb/tb_data_sram_responder.sv
// Scoreboard bench for data_sram_responder.
// It drives one instance at LATENCY=1 and one instance at LATENCY=3.
module tb_data_sram_responder;

    typedef struct {
        int          due;
        logic        rd;
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst1, en1, rv1, err1, rdy1;
    logic [3:0]  wen1;
    logic [31:0] addr1, wdata1, rdata1;
    logic        rst3, en3, rv3, err3, rdy3;
    logic [3:0]  wen3;
    logic [31:0] addr3, wdata3, rdata3;

    exp_t        q1[$];
    exp_t        q3[$];
    logic [31:0] m1 [1024];
    logic [31:0] m3 [1024];
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    data_sram_responder #(.ADDR_W(10), .BASE_ADDR(32'h8000_0000), .LATENCY(1), .INIT_CLEAR(1'b1)) dut1 (
        .clk(clk), .rst(rst1), .data_sram_en(en1), .data_sram_wen(wen1),
        .data_sram_addr(addr1), .data_sram_wdata(wdata1), .data_sram_rdata(rdata1),
        .rd_valid(rv1), .sram_err(err1), .sram_ready(rdy1));

    data_sram_responder #(.ADDR_W(10), .BASE_ADDR(32'h8000_0000), .LATENCY(3), .INIT_CLEAR(1'b1)) dut3 (
        .clk(clk), .rst(rst3), .data_sram_en(en3), .data_sram_wen(wen3),
        .data_sram_addr(addr3), .data_sram_wdata(wdata3), .data_sram_rdata(rdata3),
        .rd_valid(rv3), .sram_err(err3), .sram_ready(rdy3));

    // Advance one cycle, then match each instance's outputs against its scoreboard.
    task automatic tick();
        exp_t x;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (q1.size() != 0 && q1[0].due == cyc) begin
            x = q1.pop_front();
            vectors++;
            if (rv1 !== x.rd || err1 !== x.err || (x.rd && rdata1 !== x.data)) begin
                miscompares++;
                $display("FAIL rsp_lat1 cyc %0d: got rv=%b err=%b rdata=%h, want rv=%b err=%b rdata=%h",
                         cyc, rv1, err1, rdata1, x.rd, x.err, x.data);
            end
        end else if (rv1 !== 1'b0 || err1 !== 1'b0) begin
            vectors++;
            miscompares++;
            $display("FAIL spurious_lat1 cyc %0d: got rv=%b err=%b, want rv=0 err=0", cyc, rv1, err1);
        end
        if (q3.size() != 0 && q3[0].due == cyc) begin
            x = q3.pop_front();
            vectors++;
            if (rv3 !== x.rd || err3 !== x.err || (x.rd && rdata3 !== x.data)) begin
                miscompares++;
                $display("FAIL rsp_lat3 cyc %0d: got rv=%b err=%b rdata=%h, want rv=%b err=%b rdata=%h",
                         cyc, rv3, err3, rdata3, x.rd, x.err, x.data);
            end
        end else if (rv3 !== 1'b0 || err3 !== 1'b0) begin
            vectors++;
            miscompares++;
            $display("FAIL spurious_lat3 cyc %0d: got rv=%b err=%b, want rv=0 err=0", cyc, rv3, err3);
        end
    endtask

    // Issue one request on instance d (0: LATENCY 1, 1: LATENCY 3) and record what it must return.
    task automatic req(input int d, input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata);
        exp_t x;
        logic win;
        int   idx;
        win    = ((addr & 32'hFFFF_F000) == 32'h8000_0000);
        idx    = int'(addr[11:2]);
        x.due  = cyc + ((d == 0) ? 1 : 3);
        x.rd   = (wen == 4'b0000);
        x.err  = !win;
        x.data = 32'h0000_0000;
        if (d == 0) begin
            en1 = 1'b1; wen1 = wen; addr1 = addr; wdata1 = wdata;
        end else begin
            en3 = 1'b1; wen3 = wen; addr3 = addr; wdata3 = wdata;
        end
        if (x.rd) begin
            if (win) x.data = (d == 0) ? m1[idx] : m3[idx];
            if (d == 0) q1.push_back(x); else q3.push_back(x);
        end else if (win) begin
            for (int i = 0; i < 4; i++) begin
                if (wen[i]) begin
                    if (d == 0) m1[idx][8*i +: 8] = wdata[8*i +: 8];
                    else        m3[idx][8*i +: 8] = wdata[8*i +: 8];
                end
            end
        end else begin
            if (d == 0) q1.push_back(x); else q3.push_back(x);
        end
        tick();
        if (d == 0) en1 = 1'b0; else en3 = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q1.size() != 0 || q3.size() != 0) && n < 20) begin
            tick();
            n++;
        end
        vectors++;
        if (q1.size() != 0 || q3.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d/%0d pending responses, want 0/0", q1.size(), q3.size());
            q1.delete();
            q3.delete();
        end
    endtask

    task automatic test_reset();
        rst1 = 1'b1; rst3 = 1'b1;
        en1 = 1'b0; wen1 = 4'h0; addr1 = 32'h0; wdata1 = 32'h0;
        en3 = 1'b0; wen3 = 4'h0; addr3 = 32'h0; wdata3 = 32'h0;
        tick();
        tick();
        vectors++;
        if ({rdata1, rv1, err1, rdy1} !== 35'h0 || {rdata3, rv3, err3, rdy3} !== 35'h0) begin
            miscompares++;
            $display("FAIL reset_state: got %h/%b%b%b and %h/%b%b%b, want all zero",
                     rdata1, rv1, err1, rdy1, rdata3, rv3, err3, rdy3);
        end
    endtask

    task automatic test_init_sweep();
        int n = 0;
        rst1 = 1'b0; rst3 = 1'b0;
        while (rdy1 !== 1'b1 && n < 1100) begin
            en1 = 1'b1; wen1 = n[0] ? 4'hF : 4'h0; addr1 = 32'h8000_0000; wdata1 = 32'hBAD0_BAD0;
            tick();
            n++;
        end
        en1 = 1'b0;
        vectors++;
        if (n != 1024 || rdy3 !== 1'b1) begin
            miscompares++;
            $display("FAIL sweep_ready: got %0d cycles (lat3 ready=%b), want 1024 (ready=1)", n, rdy3);
        end
        for (int i = 0; i < 1024; i++) begin
            m1[i] = 32'h0; m3[i] = 32'h0;
        end
        req(0, 4'h0, 32'h8000_0010, 32'h0);
        req(0, 4'h0, 32'h8000_0000, 32'h0);
        drain();
    endtask

    task automatic test_write_read();
        req(0, 4'hF, 32'h8000_0004, 32'hDEAD_BEEF);
        req(0, 4'h0, 32'h8000_0004, 32'h0);
        drain();
        tick();
        vectors++;
        if (rdata1 !== 32'hDEAD_BEEF || rv1 !== 1'b0) begin
            miscompares++;
            $display("FAIL rdata_hold: got %h rv=%b, want DEADBEEF rv=0", rdata1, rv1);
        end
    endtask

    task automatic test_byte_lanes();
        req(0, 4'b0101, 32'h8000_0004, 32'h1122_3344);
        req(0, 4'h0, 32'h8000_0004, 32'h0);
        drain();
        vectors++;
        if (rdata1 !== 32'hDE22_BE44) begin
            miscompares++;
            $display("FAIL byte_lanes: got %h, want DE22BE44", rdata1);
        end
    endtask

    task automatic test_window();
        req(0, 4'h0, 32'h9000_0000, 32'h0);
        req(0, 4'hF, 32'h9000_0004, 32'hCAFE_F00D);
        req(0, 4'h0, 32'h8000_0004, 32'h0);
        drain();
        vectors++;
        if (rdata1 !== 32'hDE22_BE44) begin
            miscompares++;
            $display("FAIL oow_write: got %h, want DE22BE44", rdata1);
        end
        req(0, 4'hF, 32'h8000_0FFC, 32'h0BAD_CAFE);
        req(0, 4'h0, 32'h8000_0FFF, 32'h0);
        req(0, 4'hF, 32'h8000_1000, 32'h5555_5555);
        req(0, 4'h0, 32'h7FFF_FFFC, 32'h0);
        req(0, 4'h0, 32'h8000_0000, 32'h0);
        drain();
    endtask

    task automatic test_back_to_back();
        req(1, 4'hF, 32'h8000_0000, 32'hA0A0_0000);
        req(1, 4'hF, 32'h8000_0004, 32'hA1A1_1111);
        req(1, 4'hF, 32'h8000_0008, 32'hA2A2_2222);
        req(1, 4'h0, 32'h8000_0000, 32'h0);
        req(1, 4'h0, 32'h8000_0004, 32'h0);
        req(1, 4'h0, 32'h8000_0008, 32'h0);
        drain();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 60; i++) begin
                logic [31:0] a;
                logic [3:0]  w;
                a = 32'h8000_0000 + 32'($urandom_range(0, 7)) * 32'd4;
                if ($urandom_range(0, 7) == 0) a = a | 32'hA000_0000;
                w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                req(d, w, a, $urandom);
            end
            drain();
        end
    endtask

    task automatic test_reset_mid_sweep();
        int n = 0;
        req(0, 4'hF, 32'h8000_0008, 32'h1234_5678);
        req(0, 4'h0, 32'h8000_0008, 32'h0);
        drain();
        #2;
        rst1 = 1'b1;
        #1;
        vectors++;
        if ({rdata1, rv1, err1, rdy1} !== 35'h0) begin
            miscompares++;
            $display("FAIL async_reset: got rdata=%h rv=%b err=%b ready=%b, want all zero",
                     rdata1, rv1, err1, rdy1);
        end
        tick();
        rst1 = 1'b0;
        repeat (500) tick();
        rst1 = 1'b1;
        tick();
        rst1 = 1'b0;
        while (rdy1 !== 1'b1 && n < 1100) begin
            tick();
            n++;
        end
        vectors++;
        if (n != 1024) begin
            miscompares++;
            $display("FAIL restart_sweep: got %0d cycles, want 1024", n);
        end
        for (int i = 0; i < 1024; i++) m1[i] = 32'h0;
        req(0, 4'h0, 32'h8000_0008, 32'h0);
        req(0, 4'h0, 32'h8000_0FFC, 32'h0);
        drain();
    endtask

    initial begin
        test_reset();
        test_init_sweep();
        test_write_read();
        test_byte_lanes();
        test_window();
        test_back_to_back();
        test_reset_mid_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
